// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory arbiter.
// Contents:
//   SZ_B/SZ_H/SZ_W/SZ_D : access size encodings (1/2/4/8 bytes)
//   state_t             : arbiter FSM states
//   size_bytes()        : size encoding -> byte count
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,   // free, may accept one request
        RESP = 1'b1    // holding the response for the granted port
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        size_bytes = 4'd1 << size;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// One requester's request/response channel into the data memory arbiter.
// Signals:
//   rqValid/rqReady   request handshake; rqAddr, rqWdata, rqSize, rqSext, rqWe request fields
//   rspValid/rspReady response handshake; rspRdata, rspErr response fields
// Handshake rules (both channels): a transfer happens on a rising clock edge where valid
// and ready are both high. The sender holds valid and all fields stable until that edge;
// ready may depend combinationally on valid, valid never depends on ready.
// Modports: master = requester side, slave = arbiter side.
interface data_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64
);
    logic                  rqValid;
    logic                  rqReady;
    logic [ADDR_WIDTH-1:0] rqAddr;
    logic [DATA_WIDTH-1:0] rqWdata;
    logic [1:0]            rqSize;
    logic                  rqSext;
    logic                  rqWe;
    logic                  rspValid;
    logic                  rspReady;
    logic [DATA_WIDTH-1:0] rspRdata;
    logic                  rspErr;

    modport master (
        output rqValid, rqAddr, rqWdata, rqSize, rqSext, rqWe, rspReady,
        input  rqReady, rspValid, rspRdata, rspErr
    );

    modport slave (
        input  rqValid, rqAddr, rqWdata, rqSize, rqSext, rqWe, rspReady,
        output rqReady, rspValid, rspRdata, rspErr
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request lines
//   advance    : the current grant was taken this cycle; rotate priority
//   grant[1:0] : one-hot (or zero) grant
//   prio       : port currently preferred when both request (debug visibility)
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       prio
);
    always_comb begin
        grant = 2'b00;
        if (!prio) begin
            grant[0] = req[0];
            grant[1] = req[1] & ~req[0];
        end else begin
            grant[1] = req[1];
            grant[0] = req[0] & ~req[1];
        end
    end

    // After serving port 0 prefer port 1 and vice versa.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= grant[0];
        end
    end
endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between port 0 (load/store unit) and port 1
// (debug/program loader). One access in flight; the response is registered and held
// until the requester takes it. Misaligned / out-of-range accesses never touch memory
// and return rspErr=1 with zero data.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   rq0, rq1        : requester channels (slave side)
//   mem_*           : single-port memory (combinational read, write on rising edge)
//   dbgState, dbgPrio : FSM state and round-robin preferred port
module data_memory_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_arbiter_if.slave  rq0,
    data_memory_arbiter_if.slave  rq1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_sign_ext,
    output logic [1:0]            mem_write_size,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output state_t                dbgState,
    output logic                  dbgPrio
);
    state_t                state;
    state_t                stateNext;
    logic [1:0]            req;
    logic [1:0]            grant;
    logic                  accept;
    logic                  selPort;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [1:0]            selSize;
    logic                  selWe;
    logic                  aligned;
    logic                  inRange;
    logic                  legal;
    logic [ADDR_WIDTH:0]   endAddr;
    logic                  respPort;
    logic [DATA_WIDTH-1:0] respData;
    logic                  respErr;
    logic                  respTaken;

    // Arbitration only in IDLE and never while reset is held.
    assign req    = {rq1.rqValid, rq0.rqValid} & {2{(state == IDLE) && !reset}};
    assign accept = |grant;

    rr_arbiter2 uArb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .grant   (grant),
        .prio    (dbgPrio)
    );

    assign rq0.rqReady = grant[0];
    assign rq1.rqReady = grant[1];

    assign selPort = grant[1];
    assign selAddr = selPort ? rq1.rqAddr : rq0.rqAddr;
    assign selSize = selPort ? rq1.rqSize : rq0.rqSize;
    assign selWe   = selPort ? rq1.rqWe   : rq0.rqWe;

    always_comb begin
        aligned = 1'b1;
        case (selSize)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = (selAddr[0]   == 1'b0);
            SZ_W:    aligned = (selAddr[1:0] == 2'b00);
            default: aligned = (selAddr[2:0] == 3'b000);
        endcase
    end

    // End address computed one bit wider so the last byte of memory is reachable.
    assign endAddr = {1'b0, selAddr} + {{(ADDR_WIDTH-3){1'b0}}, size_bytes(selSize)};
    assign inRange = endAddr <= {1'b1, {ADDR_WIDTH{1'b0}}};
    assign legal   = aligned & inRange;

    // Memory is driven from the selected request; only the write enable is qualified.
    assign mem_address    = selAddr;
    assign mem_write_data = selPort ? rq1.rqWdata : rq0.rqWdata;
    assign mem_sign_ext   = selPort ? rq1.rqSext  : rq0.rqSext;
    assign mem_write_size = selSize;
    assign mem_write_en   = accept & selWe & legal;

    assign respTaken = respPort ? rq1.rspReady : rq0.rspReady;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept)    stateNext = RESP;
            RESP:    if (respTaken) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            respPort <= 1'b0;
            respData <= '0;
            respErr  <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                respPort <= selPort;
                respErr  <= ~legal;
                respData <= (legal && !selWe) ? mem_read_data : '0;
            end
        end
    end

    assign rq0.rspValid = (state == RESP) && !respPort;
    assign rq1.rspValid = (state == RESP) &&  respPort;
    assign rq0.rspRdata = rq0.rspValid ? respData : '0;
    assign rq1.rspRdata = rq1.rspValid ? respData : '0;
    assign rq0.rspErr   = rq0.rspValid & respErr;
    assign rq1.rspErr   = rq1.rspValid & respErr;

    assign dbgState = state;
endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        reset;
    logic [10:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_sign_ext;
    logic [1:0]  mem_write_size;
    logic        mem_write_en;
    logic [63:0] mem_read_data;
    state_t      dbgState;
    logic        dbgPrio;

    data_memory_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(64)) p0 ();
    data_memory_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(64)) p1 ();

    data_memory_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .rq0            (p0.slave),
        .rq1            (p1.slave),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_sign_ext   (mem_sign_ext),
        .mem_write_size (mem_write_size),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data),
        .dbgState       (dbgState),
        .dbgPrio        (dbgPrio)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0] mem [0:2047];
    logic       memClear;
    int         writeCount;

    always_comb begin
        int   nb;
        logic sb;
        mem_read_data = '0;
        nb = 1 << mem_write_size;
        for (int k = 0; k < 8; k++) begin
            if (k < nb) mem_read_data[8*k +: 8] = mem[mem_address + 11'(k)];
        end
        sb = mem_read_data[8*nb-1];
        for (int k = 0; k < 64; k++) begin
            if (k >= 8*nb) mem_read_data[k] = mem_sign_ext & sb;
        end
    end

    always @(posedge clk) begin
        if (memClear) begin
            for (int k = 0; k < 2048; k++) mem[k] <= 8'h00;
            writeCount <= 0;
        end else if (mem_write_en) begin
            for (int k = 0; k < 8; k++) begin
                if (k < (1 << mem_write_size))
                    mem[mem_address + 11'(k)] <= mem_write_data[8*k +: 8];
            end
            writeCount <= writeCount + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int          total;
    int          bad;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic driveRq(input int p, input logic v, input logic we, input logic [10:0] addr,
                           input logic [1:0] size, input logic sext, input logic [63:0] wdata);
        if (p == 0) begin
            p0.rqValid = v; p0.rqWe = we; p0.rqAddr = addr;
            p0.rqSize = size; p0.rqSext = sext; p0.rqWdata = wdata;
        end else begin
            p1.rqValid = v; p1.rqWe = we; p1.rqAddr = addr;
            p1.rqSize = size; p1.rqSext = sext; p1.rqWdata = wdata;
        end
    endtask

    // One complete access on port p; returns the response (valid, data, err).
    task automatic doAccess(input int p, input logic we, input logic [10:0] addr,
                            input logic [1:0] size, input logic sext, input logic [63:0] wdata,
                            output logic rspV, output logic [63:0] rd, output logic err);
        logic got;
        got  = 1'b0;
        rspV = 1'b0;
        rd   = '0;
        err  = 1'b0;
        @(posedge clk); #1;
        driveRq(p, 1'b1, we, addr, size, sext, wdata);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? p0.rqReady : p1.rqReady) got = 1'b1;
        end
        if (!got) begin
            check("accept_timeout", 64'(got), 64'd1);
            driveRq(p, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
            return;
        end
        @(posedge clk); #1;
        driveRq(p, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        @(negedge clk);
        rspV = (p == 0) ? p0.rspValid : p1.rspValid;
        rd   = (p == 0) ? p0.rspRdata : p1.rspRdata;
        err  = (p == 0) ? p0.rspErr   : p1.rspErr;
        if (p == 0) p0.rspReady = 1'b1; else p1.rspReady = 1'b1;
        @(posedge clk); #1;
        p0.rspReady = 1'b0;
        p1.rspReady = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          port;
        logic        we;
        logic [10:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [63:0] wdata;
        logic [63:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic        rspV;
        logic [63:0] rd;
        logic        err;
        int          wc;
        int          order[4];
        int          when[4];
        int          nAcc;
        int          c0;
        int          c1;
        logic        sawBoth;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        memClear = 1'b1;
        p0.rspReady = 1'b0;
        p1.rspReady = 1'b0;
        driveRq(0, 1'b1, 1'b0, 11'd0, SZ_B, 1'b0, '0);
        driveRq(1, 1'b1, 1'b0, 11'd4, SZ_B, 1'b0, '0);

        vecs[0]  = '{0, 1, 11'd0,    SZ_D, 0, 64'h0123456789ABCDEF, 64'h0, 0};
        vecs[1]  = '{0, 0, 11'd3,    SZ_B, 0, 64'h0, 64'h89, 0};
        vecs[2]  = '{0, 0, 11'd0,    SZ_D, 0, 64'h0, 64'h0123456789ABCDEF, 0};
        vecs[3]  = '{1, 1, 11'd4,    SZ_B, 0, 64'hF0, 64'h0, 0};
        vecs[4]  = '{1, 0, 11'd4,    SZ_B, 1, 64'h0, 64'hFFFFFFFFFFFFFFF0, 0};
        vecs[5]  = '{1, 0, 11'd4,    SZ_B, 0, 64'h0, 64'h00000000000000F0, 0};
        vecs[6]  = '{0, 0, 11'd0,    SZ_D, 0, 64'h0, 64'h012345F089ABCDEF, 0};
        vecs[7]  = '{0, 1, 11'd3,    SZ_W, 0, 64'hDEADBEEF, 64'h0, 1};
        vecs[8]  = '{0, 0, 11'd0,    SZ_D, 0, 64'h0, 64'h012345F089ABCDEF, 0};
        vecs[9]  = '{0, 0, 11'd2047, SZ_H, 0, 64'h0, 64'h0, 1};
        vecs[10] = '{0, 1, 11'd2040, SZ_D, 0, 64'hA5A5A5A55A5A5A5A, 64'h0, 0};
        vecs[11] = '{1, 0, 11'd2040, SZ_D, 0, 64'h0, 64'hA5A5A5A55A5A5A5A, 0};
        vecs[12] = '{0, 0, 11'd2047, SZ_B, 1, 64'h0, 64'hFFFFFFFFFFFFFFA5, 0};
        vecs[13] = '{0, 0, 11'd2,    SZ_H, 1, 64'h0, 64'hFFFFFFFFFFFF89AB, 0};
        vecs[14] = '{1, 0, 11'd4,    SZ_W, 0, 64'h0, 64'h00000000012345F0, 0};
        vecs[15] = '{0, 0, 11'd2046, SZ_W, 0, 64'h0, 64'h0, 1};

        // ---- reset state (valids high during reset must not be granted) ----
        repeat (3) @(posedge clk);
        #1 memClear = 1'b0;
        @(negedge clk);
        check("rst_rq0_ready", 64'(p0.rqReady), 64'd0);
        check("rst_rq1_ready", 64'(p1.rqReady), 64'd0);
        check("rst_rsp0_valid", 64'(p0.rspValid), 64'd0);
        check("rst_rsp1_valid", 64'(p1.rspValid), 64'd0);
        check("rst_rsp0_rdata", p0.rspRdata, 64'd0);
        check("rst_rsp0_err", 64'(p0.rspErr), 64'd0);
        check("rst_write_en", 64'(mem_write_en), 64'd0);
        check("rst_state", 64'(dbgState), 64'(IDLE));
        check("rst_prio", 64'(dbgPrio), 64'd0);
        driveRq(0, 1'b0, 1'b0, '0, SZ_B, 1'b0, '0);
        driveRq(1, 1'b0, 1'b0, '0, SZ_B, 1'b0, '0);
        @(posedge clk); #1 reset = 1'b0;

        // ---- table-driven accesses ----
        foreach (vecs[i]) begin
            wc = writeCount;
            exp_q.push_back(vecs[i].expRd);
            doAccess(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sext,
                     vecs[i].wdata, rspV, rd, err);
            check($sformatf("v%0d_latency", i), 64'(rspV), 64'd1);
            check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
            check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].expErr));
            check($sformatf("v%0d_writes", i), 64'(writeCount - wc),
                  64'((vecs[i].we && !vecs[i].expErr) ? 1 : 0));
        end

        // ---- round-robin alternation from reset ----
        pulseReset();
        p0.rspReady = 1'b1;
        p1.rspReady = 1'b1;
        driveRq(0, 1'b1, 1'b0, 11'd0, SZ_B, 1'b0, '0);
        driveRq(1, 1'b1, 1'b0, 11'd4, SZ_B, 1'b0, '0);
        nAcc = 0; c0 = 0; c1 = 0; sawBoth = 1'b0;
        for (int i = 0; i < 40 && nAcc < 4; i++) begin
            @(negedge clk);
            if (p0.rqReady && p1.rqReady) sawBoth = 1'b1;
            if (p0.rqReady) begin order[nAcc] = 0; when[nAcc] = i; nAcc++; c0++; end
            else if (p1.rqReady) begin order[nAcc] = 1; when[nAcc] = i; nAcc++; c1++; end
            @(posedge clk); #1;
            if (c0 == 2) p0.rqValid = 1'b0;
            if (c1 == 2) p1.rqValid = 1'b0;
        end
        @(posedge clk); #1;
        p0.rqValid = 1'b0;
        p1.rqValid = 1'b0;
        p0.rspReady = 1'b0;
        p1.rspReady = 1'b0;
        check("rr_accepts", 64'(nAcc), 64'd4);
        check("rr_no_dual_grant", 64'(sawBoth), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < nAcc) begin
                check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % 2));
                if (i > 0) check($sformatf("rr_gap%0d", i), 64'(when[i] - when[i-1]), 64'd2);
            end
        end

        // ---- response stall: port 0 held, port 1 must wait ----
        @(posedge clk); #1;
        driveRq(0, 1'b1, 1'b0, 11'd0, SZ_D, 1'b0, '0);
        @(negedge clk);
        check("stall_accept0", 64'(p0.rqReady), 64'd1);
        @(posedge clk); #1;
        driveRq(0, 1'b0, 1'b0, '0, SZ_B, 1'b0, '0);
        driveRq(1, 1'b1, 1'b0, 11'd4, SZ_B, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", i), 64'(p0.rspValid), 64'd1);
            check($sformatf("stall%0d_rdata", i), p0.rspRdata, 64'h012345F089ABCDEF);
            check($sformatf("stall%0d_rq1_ready", i), 64'(p1.rqReady), 64'd0);
        end
        p0.rspReady = 1'b1;
        @(posedge clk); #1;
        p0.rspReady = 1'b0;
        @(negedge clk);
        check("stall_rq1_granted", 64'(p1.rqReady), 64'd1);
        @(posedge clk); #1;
        driveRq(1, 1'b0, 1'b0, '0, SZ_B, 1'b0, '0);
        @(negedge clk);
        check("stall_rsp1_valid", 64'(p1.rspValid), 64'd1);
        check("stall_rsp1_rdata", p1.rspRdata, 64'hF0);
        p1.rspReady = 1'b1;
        @(posedge clk); #1;
        p1.rspReady = 1'b0;

        // ---- reset while holding a store response ----
        wc = writeCount;
        driveRq(0, 1'b1, 1'b1, 11'd8, SZ_D, 1'b0, 64'h1122334455667788);
        @(negedge clk);
        check("rstresp_accept", 64'(p0.rqReady), 64'd1);
        @(posedge clk); #1;
        driveRq(0, 1'b0, 1'b0, '0, SZ_B, 1'b0, '0);
        check("rstresp_prio_moved", 64'(dbgPrio), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstresp_rsp0_valid", 64'(p0.rspValid), 64'd0);
        check("rstresp_state", 64'(dbgState), 64'(IDLE));
        check("rstresp_prio", 64'(dbgPrio), 64'd0);
        check("rstresp_writes", 64'(writeCount - wc), 64'd1);
        doAccess(0, 1'b0, 11'd8, SZ_D, 1'b0, '0, rspV, rd, err);
        check("rstresp_readback", rd, 64'h1122334455667788);
        check("rstresp_readback_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
